branch_target_predictor: RTL

//  Parametrised branch target buffer with 2-bit saturating direction counters for the pipelined core.

---
 rtl/branch_target_predictor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/branch_target_predictor.sv
// Branch target buffer with 2-bit saturating direction counters, a sequential invalidate sweep
// and saturating statistics counters. Lookup is combinational; training happens on posedge.
module branch_target_predictor #(
  parameter int XLEN     = 64,
  parameter int ENTRIES  = 16,
  parameter int TAG_BITS = 12,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   pc_f,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_next_pc,
  input  logic              upd_valid,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_is_jump,
  input  logic              upd_mispred,
  input  logic              flush_req,
  output logic              busy,
  output logic              flush_done,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispred
);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    sp;

  logic [ENTRIES-1:0]  valid;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [XLEN-1:0]     target_mem [ENTRIES];
  logic [1:0]          ctr_mem    [ENTRIES];
  logic [ENTRIES-1:0]  jmp_mem;

  logic [IDX_W-1:0]    f_idx, u_idx;
  logic [TAG_BITS-1:0] f_tag, u_tag;
  logic                u_hit, accept;
  logic [1:0]          u_ctr_next;

  // PC bits outside the index/tag fields deliberately do not take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f[XLEN-1:IDX_W+TAG_BITS+2], pc_f[1:0],
                            upd_pc[XLEN-1:IDX_W+TAG_BITS+2], upd_pc[1:0]};

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[IDX_W+TAG_BITS+1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[IDX_W+TAG_BITS+1:IDX_W+2];

  // Lookup sees pre-update contents; there is no bypass from the training port.
  assign pred_hit     = !busy && valid[f_idx] && (tag_mem[f_idx] == f_tag);
  assign pred_taken   = pred_hit && (jmp_mem[f_idx] || ctr_mem[f_idx][1]);
  assign pred_next_pc = pred_taken ? target_mem[f_idx] : pc_f + XLEN'(4);

  assign accept = upd_valid && !busy;
  assign u_hit  = valid[u_idx] && (tag_mem[u_idx] == u_tag);

  always_comb begin
    u_ctr_next = ctr_mem[u_idx];
    if (upd_taken && ctr_mem[u_idx] != 2'b11)       u_ctr_next = ctr_mem[u_idx] + 2'd1;
    else if (!upd_taken && ctr_mem[u_idx] != 2'b00) u_ctr_next = ctr_mem[u_idx] - 2'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sp    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= state_next;
      sp    <= (state == SWEEP) ? sp + IDX_W'(1) : '0;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    flush_done = 1'b0;
    unique case (state)
      IDLE:  if (flush_req) state_next = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (sp == IDX_W'(ENTRIES - 1)) begin
          flush_done = 1'b1;
          state_next = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (state == SWEEP) begin
      valid[sp] <= 1'b0;
    end else if (accept && !u_hit && upd_taken) begin
      valid[u_idx] <= 1'b1;
    end
  end

  // NOTE: entry payload has no reset; it is only ever observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (u_hit) begin
        ctr_mem[u_idx] <= u_ctr_next;
        if (upd_taken) begin
          target_mem[u_idx] <= upd_target;
          jmp_mem[u_idx]    <= upd_is_jump;
        end
      end else if (upd_taken) begin
        tag_mem[u_idx]    <= u_tag;
        target_mem[u_idx] <= upd_target;
        jmp_mem[u_idx]    <= upd_is_jump;
        ctr_mem[u_idx]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else if (accept) begin
      if (stat_updates != '1)                stat_updates <= stat_updates + STAT_W'(1);
      if (upd_mispred && stat_mispred != '1) stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end

endmodule
